// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper slice.
// Optional feature macro used elsewhere in this slice: HIGH_SCORE_EN.
package score_pkg;

   localparam int unsigned SCORE_W    = 17;
   localparam int unsigned NUM_DIGITS = 5;
   localparam int unsigned MAX_SCORE  = 99999;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [NUM_DIGITS-1:0] bcd_digits_t;

   // Legacy encodings kept so existing tooling that decodes the state bits still works
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } conv_state_t;

   // Double-dabble correction: every nibble >= 5 gets +3 before the left shift
   function automatic bcd_digits_t dabble_adjust(input bcd_digits_t d);
      bcd_digits_t r;
      r = d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (d[i] >= 4'd5) r[i] = d[i] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Event/display bus between the game logic and the score keeper.
// high_score exists only when HIGH_SCORE_EN is defined.
interface score_keeper_if #(parameter int unsigned PTS_W = 8);
   import score_pkg::*;

   logic                 add_valid;
   logic [PTS_W-1:0]     add_pts;
   logic                 clear;
   logic                 frame_start;
   logic [SCORE_W-1:0]   score;
   bcd_digits_t          bcd_digits;
   logic                 busy;
`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0]   high_score;
`endif

   modport master (
      output add_valid, add_pts, clear, frame_start,
`ifdef HIGH_SCORE_EN
      input  high_score,
`endif
      input  score, bcd_digits, busy
   );

   modport slave (
      input  add_valid, add_pts, clear, frame_start,
`ifdef HIGH_SCORE_EN
      output high_score,
`endif
      output score, bcd_digits, busy
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 17-bit binary to 5-digit BCD converter (double dabble, one bit per cycle).
// start is accepted in IDLE; done is high for the single DONE cycle with bcd valid.
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output logic               busy,
   output logic               done,
   output bcd_digits_t        bcd
);

   localparam int unsigned CAT_W = 4 * NUM_DIGITS + SCORE_W;

   conv_state_t        state_q, state_d;
   logic [SCORE_W-1:0] sh_q, sh_d;
   bcd_digits_t        acc_q, acc_d;
   logic [4:0]         cnt_q, cnt_d;
   bcd_digits_t        acc_adj;
   logic [CAT_W-1:0]   cat;
   logic [CAT_W-1:0]   cat_shl;

   // Next-state: load on start, adjust+shift 17 times, then one DONE cycle
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      acc_adj = dabble_adjust(acc_q);
      cat     = {acc_adj, sh_q};
      cat_shl = {cat[CAT_W-2:0], 1'b0};
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, sh_d} = cat_shl;
            if (cnt_q == 5'(SCORE_W - 1)) state_d = DONE;
            else                          cnt_d   = cnt_q + 5'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign bcd  = acc_q;

endmodule

// File: rtl/score_keeper.sv
// Saturating score accumulator with tear-free BCD display registers.
// HIGH_SCORE_EN adds a high_score register that tracks the peak score across clears.
module score_keeper #(
   parameter int unsigned MAX_SCORE = 99999,
   parameter int unsigned PTS_W     = 8
) (
   input  logic           clk,
   input  logic           reset,
   score_keeper_if.slave  bus
);
   import score_pkg::*;

   logic [SCORE_W-1:0] score_q, score_d;
   logic               dirty_q, dirty_d;
   logic               pending_q, pending_d;
   bcd_digits_t        shadow_q, shadow_d;
   bcd_digits_t        disp_q, disp_d;
`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] hs_q, hs_d;
`endif

   logic [PTS_W-1:0]   pts;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W-1:0] sat;
   logic               evt;
   logic               conv_start;
   logic               conv_busy;
   logic               conv_done;
   bcd_digits_t        conv_bcd;

   assign pts = bus.add_pts;

   // Accumulate, dirty/pending bookkeeping and frame-aligned display update
   always_comb begin
      sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
      sat = (sum > (SCORE_W + 1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];

      score_d = score_q;
      if (bus.clear)          score_d = '0;
      else if (bus.add_valid) score_d = sat;

      // An event on the same edge as the load keeps dirty set
      evt        = bus.clear | bus.add_valid;
      conv_start = dirty_q & ~conv_busy;
      dirty_d    = evt | (dirty_q & ~conv_start);

      shadow_d = conv_done ? conv_bcd : shadow_q;

      pending_d = pending_q;
      if (bus.frame_start) pending_d = 1'b0;
      else if (conv_done)  pending_d = 1'b1;

      // A result finishing on the frame edge goes straight to the display
      disp_d = disp_q;
      if (bus.frame_start && conv_done)      disp_d = conv_bcd;
      else if (bus.frame_start && pending_q) disp_d = shadow_q;

`ifdef HIGH_SCORE_EN
      hs_d = (score_q > hs_q) ? score_q : hs_q;
`endif
   end

   // Top-level state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q   <= '0;
         dirty_q   <= 1'b0;
         pending_q <= 1'b0;
         shadow_q  <= '0;
         disp_q    <= '0;
`ifdef HIGH_SCORE_EN
         hs_q      <= '0;
`endif
      end else begin
         score_q   <= score_d;
         dirty_q   <= dirty_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
`ifdef HIGH_SCORE_EN
         hs_q      <= hs_d;
`endif
      end
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (score_q),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   assign bus.score      = score_q;
   assign bus.bcd_digits = disp_q;
   assign bus.busy       = conv_busy;
`ifdef HIGH_SCORE_EN
   assign bus.high_score = hs_q;
`endif

endmodule
